// File: rtl/rca_nibble_seq.sv
// Sequential N-nibble adder that time-shares one external 4-bit ripple-carry adder.
// An operation is accepted in IDLE, runs one nibble per RUN cycle LSB-first, then holds the result in DONE.
module rca_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 op_cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES:0]   sum,
  output logic                 busy,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [4:0]           add_sum
);

  localparam int W = 4 * NIBBLES;
  localparam logic [2:0] LAST_IDX = 3'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           carry_q, carry_d;
  logic [2:0]     idx_q, idx_d;
  logic [W:0]     sum_q, sum_d;
  logic [3:0]     nib_a, nib_b;

  // Nibble select of the latched operands; idx is 3 bits wide to cover up to 8 nibbles.
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == 3'(n)) begin
        nib_a = a_q[4*n +: 4];
        nib_b = b_q[4*n +: 4];
      end
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = op_cin;
          idx_d   = 3'd0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        add_a   = nib_a;
        add_b   = nib_b;
        add_cin = carry_q;
        for (int n = 0; n < NIBBLES; n++) begin
          if (idx_q == 3'(n)) begin
            sum_d[4*n +: 4] = add_sum[3:0];
          end
        end
        carry_d = add_sum[4];
        idx_d   = idx_q + 3'd1;
        if (idx_q == LAST_IDX) begin
          sum_d[W] = add_sum[4];
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = ~in_ready;
  assign sum  = sum_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= 3'd0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_rca_nibble_seq.sv
// Self-checking bench: arithmetic reference model checked every cycle plus directed literal cases.
// Instantiates a 4-nibble and a 1-nibble build, each with its own combinational 4-bit adder.
module tb_rca_nibble_seq;

  localparam int N = 4;
  localparam int W = 4 * N;
  localparam logic [63:0] SUM_MASK = (64'd1 << (W + 1)) - 64'd1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic          op_cin = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W:0]    sum;
  logic          busy;
  logic [3:0]    add_a, add_b;
  logic          add_cin;
  logic [4:0]    add_sum;

  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  rca_nibble_seq #(.NIBBLES(N)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum)
  );

  logic       d1_in_valid = 1'b0;
  logic       d1_in_ready;
  logic [3:0] d1_op_a = '0;
  logic [3:0] d1_op_b = '0;
  logic       d1_op_cin = 1'b0;
  logic       d1_out_valid;
  logic       d1_out_ready = 1'b1;
  logic [4:0] d1_sum;
  logic       d1_busy;
  logic [3:0] d1_add_a, d1_add_b;
  logic       d1_add_cin;
  logic [4:0] d1_add_sum;

  assign d1_add_sum = {1'b0, d1_add_a} + {1'b0, d1_add_b} + {4'b0, d1_add_cin};

  rca_nibble_seq #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .op_a(d1_op_a), .op_b(d1_op_b), .op_cin(d1_op_cin),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready),
    .sum(d1_sum), .busy(d1_busy),
    .add_a(d1_add_a), .add_b(d1_add_b), .add_cin(d1_add_cin), .add_sum(d1_add_sum)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: pending operands, remaining RUN cycles, completion count.
  logic        m_active = 1'b0;
  int          m_cnt    = 0;
  logic [63:0] m_a      = '0;
  logic [63:0] m_b      = '0;
  logic [63:0] m_cin    = '0;
  int          n_done   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_cnt    <= 0;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active <= 1'b1;
        m_cnt    <= N;
        m_a      <= 64'(op_a);
        m_b      <= 64'(op_b);
        m_cin    <= 64'(op_cin);
      end
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end else if (out_ready) begin
      m_active <= 1'b0;
      n_done   <= n_done + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic [63:0] mask_k;
      int k;
      check("in_ready", 64'(in_ready), 64'(!m_active));
      check("busy", 64'(busy), 64'(m_active));
      check("out_valid", 64'(out_valid), 64'(m_active && m_cnt == 0));
      if (m_active && m_cnt != 0) begin
        k = N - m_cnt;
        mask_k = (64'd1 << (4 * k)) - 64'd1;
        check("add_a", 64'(add_a), (m_a >> (4 * k)) & 64'hF);
        check("add_b", 64'(add_b), (m_b >> (4 * k)) & 64'hF);
        check("add_cin", 64'(add_cin),
              (((m_a & mask_k) + (m_b & mask_k) + m_cin) >> (4 * k)) & 64'd1);
      end else begin
        check("add_idle", {55'd0, add_a, add_b, add_cin}, 64'd0);
      end
      if (m_active && m_cnt == 0) begin
        check("sum", 64'(sum), (m_a + m_b + m_cin) & SUM_MASK);
      end
    end
  end

  // Issues one request from IDLE; returns result, cycles to out_valid, and add_cin per RUN cycle.
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         output logic [W:0] res, output int lat, output logic [3:0] cin_tr);
    int g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("req_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 0;
    cin_tr   = 4'b0;
    while (!out_valid && lat < 20) begin
      if (lat < 4) cin_tr[lat] = add_cin;
      @(negedge clk);
      lat++;
    end
    res = sum;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0] res;
    logic [W:0] held;
    int lat;
    logic [3:0] ctr;
    int ov_seen;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_add", {55'd0, add_a, add_b, add_cin}, 64'd0);

    rst_n = 1'b1;
    run_txn(16'h1234, 16'h4321, 1'b0, res, lat, ctr);
    check("t1234_sum", 64'(res), 64'h05555);
    check("t1234_lat", 64'(lat), 64'd4);
    check("t1234_cin", 64'(ctr), 64'b0000);

    run_txn(16'hFFFF, 16'h0001, 1'b0, res, lat, ctr);
    check("ripple_sum", 64'(res), 64'h10000);
    check("ripple_lat", 64'(lat), 64'd4);
    check("ripple_cin", 64'(ctr), 64'b1110);

    run_txn(16'hFFFF, 16'hFFFF, 1'b1, res, lat, ctr);
    check("max_sum", 64'(res), 64'h1FFFF);
    check("max_cin", 64'(ctr), 64'b1111);

    // Single-nibble build: one RUN cycle.
    check("n1_ready", 64'(d1_in_ready), 64'd1);
    d1_in_valid = 1'b1;
    d1_op_a = 4'hF;
    d1_op_b = 4'h1;
    d1_op_cin = 1'b0;
    @(negedge clk);
    d1_in_valid = 1'b0;
    check("n1_run_ov", 64'(d1_out_valid), 64'd0);
    check("n1_run_add", {55'd0, d1_add_a, d1_add_b, d1_add_cin}, {55'd0, 4'hF, 4'h1, 1'b0});
    @(negedge clk);
    check("n1_ov", 64'(d1_out_valid), 64'd1);
    check("n1_sum", 64'(d1_sum), 64'h10);
    @(negedge clk);
    check("n1_idle", 64'(d1_in_ready), 64'd1);

    // Backpressure in DONE with competing in_valid.
    out_ready = 1'b0;
    in_valid = 1'b1;
    op_a = 16'hABCD;
    op_b = 16'h1111;
    op_cin = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_lat", 64'(lat), 64'd4);
    held = sum;
    check("bp_sum", 64'(held), 64'h0BCDF);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      op_a = 16'($urandom);
      op_b = 16'($urandom);
      @(negedge clk);
      check("bp_hold_sum", 64'(sum), 64'h0BCDF);
      check("bp_hold_rdy", 64'(in_ready), 64'd0);
      check("bp_hold_ov", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_rdy", 64'(in_ready), 64'd1);
    check("bp_rel_ov", 64'(out_valid), 64'd0);
    run_txn(16'h0F0F, 16'h00F1, 1'b0, res, lat, ctr);
    check("bp_next_sum", 64'(res), 64'h01000);

    // Reset during the second RUN cycle.
    @(negedge clk);
    in_valid = 1'b1;
    op_a = 16'h00FF;
    op_b = 16'h0F01;
    op_cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("rr_busy_pre", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rr_out_valid", 64'(out_valid), 64'd0);
    check("rr_busy", 64'(busy), 64'd0);
    check("rr_in_ready", 64'(in_ready), 64'd1);
    check("rr_sum", 64'(sum), 64'd0);
    check("rr_add", {55'd0, add_a, add_b, add_cin}, 64'd0);
    ov_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
      if (i == 2) rst_n = 1'b1;
    end
    check("rr_no_ov", 64'(ov_seen), 64'd0);
    run_txn(16'h0001, 16'h0001, 1'b0, res, lat, ctr);
    check("rr_next_sum", 64'(res), 64'h00002);
    check("rr_next_lat", 64'(lat), 64'd4);

    // Randomized traffic with random backpressure; the model checks every cycle.
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 1) == 1);
      op_a = 16'($urandom);
      op_b = 16'($urandom);
      op_cin = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) op_a = 16'hFFFF;
      if ($urandom_range(0, 7) == 0) op_b = 16'hFFFF - op_a;
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("rand_progress", 64'(n_done > 40), 64'd1);
    check("rand_idle", 64'(in_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
